// File: rtl/div_pkg.sv
// Shared encodings and helpers for the multi-cycle integer divider.
package div_pkg;

    localparam int REG_WIDTH = 32;
    localparam int CNT_W     = 6;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REG_WIDTH);

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    // Two's-complement magnitude when the operand is treated as signed and negative.
    function automatic logic [REG_WIDTH-1:0] mag(input logic is_signed,
                                                 input logic [REG_WIDTH-1:0] x);
        return (is_signed && x[REG_WIDTH-1]) ? -x : x;
    endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider, one quotient bit per cycle, result as {remainder, quotient}.
module div
    import div_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   signed_div_i,
    input  logic [REG_WIDTH-1:0]   opdata1_i,
    input  logic [REG_WIDTH-1:0]   opdata2_i,
    input  logic                   start_i,
    input  logic                   annul_i,
    output logic [2*REG_WIDTH-1:0] result_o,
    output logic                   ready_o
);

    div_state_e             state;
    logic [CNT_W-1:0]       cnt;
    logic [2*REG_WIDTH:0]   dividend;
    logic [REG_WIDTH-1:0]   divisor;
    logic                   neg_quot;
    logic                   neg_rem;

    logic [REG_WIDTH:0]     diff;
    logic [REG_WIDTH-1:0]   quot;
    logic [REG_WIDTH-1:0]   rem;

    assign diff = {1'b0, dividend[2*REG_WIDTH-1:REG_WIDTH]} - {1'b0, divisor};
    assign quot = neg_quot ? -dividend[REG_WIDTH-1:0] : dividend[REG_WIDTH-1:0];
    assign rem  = neg_rem  ? -dividend[2*REG_WIDTH:REG_WIDTH+1]
                           :  dividend[2*REG_WIDTH:REG_WIDTH+1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            case (state)
                DIV_FREE: begin
                    ready_o  <= DIV_RESULT_NOT_READY;
                    result_o <= '0;
                    if (start_i == DIV_START && !annul_i) begin
                        divisor  <= mag(signed_div_i, opdata2_i);
                        neg_rem  <= signed_div_i & opdata1_i[REG_WIDTH-1];
                        neg_quot <= signed_div_i & (opdata1_i[REG_WIDTH-1] ^ opdata2_i[REG_WIDTH-1]);
                        cnt      <= '0;
                        if (opdata2_i == '0) begin
                            state <= DIV_BY_ZERO;
                        end else begin
                            state    <= DIV_ON;
                            dividend <= {{REG_WIDTH{1'b0}}, mag(signed_div_i, opdata1_i), 1'b0};
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    result_o <= '0;
                    if (annul_i) begin
                        state   <= DIV_FREE;
                        ready_o <= DIV_RESULT_NOT_READY;
                    end else begin
                        state   <= DIV_END;
                        ready_o <= DIV_RESULT_READY;
                    end
                end
                DIV_ON: begin
                    if (annul_i) begin
                        state    <= DIV_FREE;
                        cnt      <= '0;
                        ready_o  <= DIV_RESULT_NOT_READY;
                        result_o <= '0;
                    end else if (cnt != LAST_CNT) begin
                        // Restore by simply not committing the difference when it underflows.
                        if (diff[REG_WIDTH])
                            dividend <= {dividend[2*REG_WIDTH-1:0], 1'b0};
                        else
                            dividend <= {diff[REG_WIDTH-1:0], dividend[REG_WIDTH-1:0], 1'b1};
                        cnt <= cnt + 1'b1;
                    end else begin
                        result_o <= {rem, quot};
                        ready_o  <= DIV_RESULT_READY;
                        state    <= DIV_END;
                    end
                end
                DIV_END: begin
                    if (start_i == DIV_STOP || annul_i) begin
                        state    <= DIV_FREE;
                        cnt      <= '0;
                        ready_o  <= DIV_RESULT_NOT_READY;
                        result_o <= '0;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

endmodule
